// File: rtl/neat_q_pkg.sv
// Types and constants shared by the circular-queue blocks.
package neat_q_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DONE
    } rd_state_t;

    localparam int RD_BUF_DEPTH = 3;

    // Pointer increment for the 3-entry output buffer.
    function automatic logic [1:0] rd_ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'(RD_BUF_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/circ_q_reader_obuf.sv
// Three-entry registered FIFO holding words popped from the queue until the
// downstream stream accepts them.
module circ_q_reader_obuf
    import neat_q_pkg::*;
#(
    parameter int WORD_SZ = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [WORD_SZ-1:0] push_data_i,
    input  logic               pop_i,
    output logic [WORD_SZ-1:0] head_o,
    output logic [1:0]         cnt_o
);

    logic [WORD_SZ-1:0] mem_q [RD_BUF_DEPTH];
    logic [1:0]         wr_ptr_q;
    logic [1:0]         rd_ptr_q;
    logic [1:0]         cnt_q;
    logic [1:0]         cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is cleared too so the stream data reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= rd_ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_d;
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/circ_q_reader.sv
// Read-side drain engine: pops len words from a circ_q (1-cycle read latency)
// and presents them on a valid/ready stream with a last flag and a done pulse.
module circ_q_reader
    import neat_q_pkg::*;
#(
    parameter int WORD_SZ = 32,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               q_rd_o,
    input  logic               q_empty_i,
    input  logic [WORD_SZ-1:0] q_data_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [WORD_SZ-1:0] m_data_o,
    output logic               m_last_o,
    output logic [LEN_W-1:0]   words_out_o
);

    // Stream handshake: a word moves when m_valid_o & m_ready_i at a rising
    // edge; once raised, valid/data/last hold until that handshake.

    rd_state_t        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic             inflight_q;
    logic             q_rd;
    logic [1:0]       buf_cnt;
    logic             m_hs;
    logic             last_word;

    assign m_valid_o = (buf_cnt != 2'd0);
    assign m_hs      = m_valid_o & m_ready_i;
    assign last_word = (words_q == len_q - LEN_W'(1));

    // Occupancy plus the word in flight must stay below the buffer depth so a
    // returning word always has a free slot regardless of m_ready_i.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        words_d  = words_q;
        q_rd     = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (start_i) begin
                    len_d    = len_i;
                    issued_d = '0;
                    words_d  = '0;
                    state_d  = (len_i == '0) ? RD_DONE : RD_RUN;
                end
            end
            RD_RUN: begin
                q_rd = !q_empty_i && (issued_q < len_q)
                       && (({1'b0, buf_cnt} + {2'b00, inflight_q}) < 3'(RD_BUF_DEPTH));
                if (q_rd) begin
                    issued_d = issued_q + LEN_W'(1);
                end
                if (m_hs) begin
                    words_d = words_q + LEN_W'(1);
                    if (last_word) begin
                        state_d = RD_DONE;
                    end
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RD_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            words_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            words_q    <= words_d;
            inflight_q <= q_rd;
        end
    end

    circ_q_reader_obuf #(
        .WORD_SZ(WORD_SZ)
    ) u_obuf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_data_i(q_data_i),
        .pop_i      (m_hs),
        .head_o     (m_data_o),
        .cnt_o      (buf_cnt)
    );

    assign q_rd_o      = q_rd;
    assign busy_o      = (state_q != RD_IDLE);
    assign done_o      = (state_q == RD_DONE);
    assign m_last_o    = m_valid_o & last_word;
    assign words_out_o = words_q;

endmodule

// File: tb/tb_circ_q_reader.sv
// Directed bench for circ_q_reader with a behavioural circular queue on the read side.
module tb_circ_q_reader;

    localparam int WORD_SZ = 32;
    localparam int LEN_W   = 16;

    logic               clk;
    logic               rst;
    logic               start;
    logic [LEN_W-1:0]   len;
    logic               busy;
    logic               done;
    logic               q_rd;
    logic               q_empty;
    logic [WORD_SZ-1:0] q_data;
    logic               m_valid;
    logic               m_ready;
    logic [WORD_SZ-1:0] m_data;
    logic               m_last;
    logic [LEN_W-1:0]   words_out;

    logic               wr_en;
    logic [WORD_SZ-1:0] wr_data;
    logic [WORD_SZ-1:0] mdl_q[$];

    logic [WORD_SZ-1:0] exp_q[$];
    logic [WORD_SZ-1:0] rx_q[$];
    logic               rx_last_q[$];

    int n_cmp;
    int n_err;
    int n_rd;
    int n_done;

    circ_q_reader #(
        .WORD_SZ(WORD_SZ),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .q_rd_o     (q_rd),
        .q_empty_i  (q_empty),
        .q_data_i   (q_data),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready),
        .m_data_o   (m_data),
        .m_last_o   (m_last),
        .words_out_o(words_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // queue model: registered read data, write visible after the edge
    always @(posedge clk) begin
        if (rst) begin
            mdl_q.delete();
            q_data  <= '0;
            q_empty <= 1'b1;
        end else begin
            if (q_rd && !q_empty) begin
                q_data <= mdl_q.pop_front();
            end
            if (wr_en) begin
                mdl_q.push_back(wr_data);
            end
            q_empty <= (mdl_q.size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic q_push(input logic [WORD_SZ-1:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int  cyc;
        bit  seen;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < budget) begin
            if (q_rd) n_rd++;
            if (m_valid && m_ready) begin
                rx_q.push_back(m_data);
                rx_last_q.push_back(m_last);
            end
            if (done) begin
                seen = 1;
                n_done++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("done_reached", 32'(seen), 32'd1);
    endtask

    // scoreboard: compare received words and last flags against exp_q
    task automatic check_rx(input string tag);
        int ne;
        int nr;
        ne = exp_q.size();
        nr = rx_q.size();
        chk({tag, "_count"}, 32'(nr), 32'(ne));
        for (int i = 0; i < ne && i < nr; i++) begin
            chk({tag, "_data"}, rx_q[i], exp_q[i]);
            chk({tag, "_last"}, 32'(rx_last_q[i]), 32'(i == ne - 1));
        end
        exp_q.delete();
        rx_q.delete();
        rx_last_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_q_rd"}, 32'(q_rd), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, m_data, 32'd0);
        chk({tag, "_m_last"}, 32'(m_last), 32'd0);
        chk({tag, "_words_out"}, 32'(words_out), 32'd0);
    endtask

    initial begin
        logic [7:0] e_rd;
        logic [7:0] e_val;
        logic [7:0] e_last;
        logic [7:0] e_done;
        logic [7:0] e_busy;

        n_cmp   = 0;
        n_err   = 0;
        n_rd    = 0;
        n_done  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        len     = '0;
        m_ready = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: len=4, queue preloaded, m_ready=1, cycle-exact timing
        for (int i = 0; i < 4; i++) q_push(32'hA0 + 32'(i));
        m_ready = 1'b1;
        e_rd   = 8'b0000_1111;
        e_val  = 8'b0011_1100;
        e_last = 8'b0010_0000;
        e_done = 8'b0100_0000;
        e_busy = 8'b0111_1111;
        start = 1'b1;
        len   = 16'd4;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("t1_q_rd", 32'(q_rd), 32'(e_rd[k]));
            chk("t1_m_valid", 32'(m_valid), 32'(e_val[k]));
            if (e_val[k]) chk("t1_m_data", m_data, 32'hA0 + 32'(k - 2));
            chk("t1_m_last", 32'(m_last), 32'(e_last[k]));
            chk("t1_done", 32'(done), 32'(e_done[k]));
            chk("t1_busy", 32'(busy), 32'(e_busy[k]));
            @(negedge clk);
        end
        chk("t1_words_out", 32'(words_out), 32'd4);

        // 2: len=6 with m_ready low -> three pops then stall
        for (int i = 0; i < 6; i++) q_push(32'hB0 + 32'(i));
        m_ready = 1'b0;
        n_rd    = 0;
        n_done  = 0;
        start   = 1'b1;
        len     = 16'd6;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (q_rd) n_rd++;
            @(negedge clk);
        end
        chk("t2_stall_rd", 32'(n_rd), 32'd3);
        chk("t2_stall_valid", 32'(m_valid), 32'd1);
        chk("t2_stall_data", m_data, 32'hB0);
        chk("t2_stall_busy", 32'(busy), 32'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'hB0 + 32'(i));
        run_until_done(40);
        chk("t2_total_rd", 32'(n_rd), 32'd6);
        check_rx("t2");
        @(negedge clk);

        // 3: start on an empty queue, words trickle in later
        m_ready = 1'b0;
        start   = 1'b1;
        len     = 16'd2;
        @(negedge clk);
        start = 1'b0;
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_q_rd_empty", 32'(q_rd), 32'd0);
        repeat (3) @(negedge clk);
        chk("t3_q_rd_still", 32'(q_rd), 32'd0);
        chk("t3_valid_none", 32'(m_valid), 32'd0);
        q_push(32'h11);
        repeat (3) @(negedge clk);
        chk("t3_first_valid", 32'(m_valid), 32'd1);
        chk("t3_first_data", m_data, 32'h11);
        chk("t3_first_last", 32'(m_last), 32'd0);
        q_push(32'h22);
        m_ready = 1'b1;
        n_done  = 0;
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        run_until_done(20);
        check_rx("t3");
        @(negedge clk);

        // 4: len=0 completes without touching queue or stream
        n_rd  = 0;
        start = 1'b1;
        len   = 16'd0;
        @(negedge clk);
        start = 1'b0;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_q_rd", 32'(q_rd), 32'd0);
        chk("t4_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t4_done_fall", 32'(done), 32'd0);
        chk("t4_busy_fall", 32'(busy), 32'd0);
        chk("t4_q_rd_after", 32'(q_rd), 32'd0);

        // 5: reset after two of five words accepted, then a fresh transfer
        for (int i = 0; i < 5; i++) q_push(32'hC0 + 32'(i));
        m_ready = 1'b1;
        start   = 1'b1;
        len     = 16'd5;
        @(negedge clk);
        start = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (words_out != 16'd2 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("t5_two_accepted", 32'(words_out), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("t5_rst");
        rst = 1'b0;
        @(negedge clk);
        q_push(32'h5A);
        n_done = 0;
        start  = 1'b1;
        len    = 16'd1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back(32'h5A);
        run_until_done(20);
        check_rx("t5");
        @(negedge clk);

        // 6: start held high with a different len while busy is ignored
        for (int i = 0; i < 4; i++) q_push(32'hD0 + 32'(i));
        m_ready = 1'b1;
        n_done  = 0;
        start   = 1'b1;
        len     = 16'd3;
        @(negedge clk);
        len = 16'd9;
        repeat (2) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hD0 + 32'(i));
        run_until_done(30);
        check_rx("t6");
        repeat (4) begin
            if (done) n_done++;
            @(negedge clk);
        end
        chk("t6_one_done", 32'(n_done), 32'd1);
        chk("t6_idle", 32'(busy), 32'd0);
        chk("t6_left_in_q", 32'(mdl_q.size()), 32'd1);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
